// File: rtl/sort_pkg.sv
// Shared definitions for the sort job scheduler.
// - state_e   : scheduler FSM states
// - CntW      : width of the saturating job statistics counters
// - dw_of     : packed vector width from element count and element width
// - id_w_of   : requester ID width for a given requester count
// - sat_inc   : saturating increment for statistics counters
package sort_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StLaunch,
    StWait,
    StResp
  } state_e;

  localparam int unsigned CntW = 16;

  function automatic int unsigned dw_of(input int unsigned n, input int unsigned w);
    return n * w;
  endfunction

  function automatic int unsigned id_w_of(input int unsigned nreq);
    return (nreq > 1) ? $clog2(nreq) : 1;
  endfunction

  function automatic logic [CntW-1:0] sat_inc(input logic [CntW-1:0] v);
    return (v == '1) ? v : v + CntW'(1);
  endfunction

endpackage

// File: rtl/sort_rr_arbiter.sv
// Combinational round-robin arbiter.
// - req : request vector
// - ptr : requester index with highest priority this cycle
// - en  : grant enable; gnt is all-zero when low
// - gnt : one-hot grant (all-zero when no request or not enabled)
module sort_rr_arbiter
  import sort_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  localparam int unsigned IdW = id_w_of(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IdW-1:0]  ptr,
  input  logic            en,
  output logic [NREQ-1:0] gnt
);

  logic [2*NREQ-1:0] dbl_req;
  logic [2*NREQ-1:0] dbl_gnt;
  logic [NREQ-1:0]   rot_req;
  logic [NREQ-1:0]   rot_gnt;

  always_comb begin
    // Rotate so that requester ptr sits at bit 0, isolate the lowest set bit,
    // then rotate the winner back into place.
    dbl_req = {req, req} >> ptr;
    rot_req = dbl_req[NREQ-1:0];
    rot_gnt = rot_req & (~rot_req + NREQ'(1));
    dbl_gnt = {rot_gnt, rot_gnt} << ptr;
    gnt     = en ? dbl_gnt[2*NREQ-1:NREQ] : '0;
  end

endmodule

// File: rtl/sort_job_scheduler.sv
// Round-robin scheduler sharing one external sorter among NREQ requesters.
// - clk, rst_n                 : clock, synchronous active-low reset
// - req_valid/req_data/req_ready : per-requester job intake (one-hot accept)
// - rsp_valid/rsp_ready/rsp_id/rsp_data/rsp_err : shared response channel
// - srt_start/srt_data_in/srt_data_out/srt_done : sorter control and result
// - jobs_ok/jobs_err           : saturating completion / timeout counters
module sort_job_scheduler
  import sort_pkg::*;
#(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned N       = 4,
  parameter int unsigned W       = 8,
  parameter int unsigned TIMEOUT = 64,
  localparam int unsigned DW     = dw_of(N, W),
  localparam int unsigned IdW    = id_w_of(NREQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]    req_ready,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [IdW-1:0]     rsp_id,
  output logic [DW-1:0]      rsp_data,
  output logic               rsp_err,
  output logic               srt_start,
  output logic [DW-1:0]      srt_data_in,
  input  logic [DW-1:0]      srt_data_out,
  input  logic               srt_done,
  output logic [CntW-1:0]    jobs_ok,
  output logic [CntW-1:0]    jobs_err
);

  localparam int unsigned    TmoW    = $clog2(TIMEOUT);
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT - 1);
  localparam logic [IdW-1:0]  IdLast  = IdW'(NREQ - 1);

  state_e          state_q, state_d;
  logic [IdW-1:0]  ptr_q, ptr_d;
  logic [IdW-1:0]  id_q, id_d;
  logic [TmoW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic [DW-1:0]   job_q, job_d;
  logic [DW-1:0]   rsp_data_q, rsp_data_d;
  logic            rsp_err_q, rsp_err_d;
  logic [CntW-1:0] jobs_ok_q, jobs_ok_d;
  logic [CntW-1:0] jobs_err_q, jobs_err_d;

  logic [NREQ-1:0] gnt;
  logic [DW-1:0]   gnt_data;
  logic [IdW-1:0]  gnt_id;

  sort_rr_arbiter #(
    .NREQ(NREQ)
  ) u_arb (
    .req(req_valid),
    .ptr(ptr_q),
    .en (state_q == StIdle),
    .gnt(gnt)
  );

  // Select the granted requester's vector and index.
  always_comb begin
    gnt_data = '0;
    gnt_id   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        gnt_data = req_data[i*DW +: DW];
        gnt_id   = IdW'(i);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    id_d       = id_q;
    tmo_cnt_d  = tmo_cnt_q;
    job_d      = job_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    jobs_ok_d  = jobs_ok_q;
    jobs_err_d = jobs_err_q;

    unique case (state_q)
      StIdle: begin
        if (|gnt) begin
          job_d   = gnt_data;
          id_d    = gnt_id;
          state_d = StLaunch;
        end
      end
      StLaunch: begin
        tmo_cnt_d = '0;
        state_d   = StWait;
      end
      StWait: begin
        tmo_cnt_d = tmo_cnt_q + TmoW'(1);
        // A zero count marks the first WAIT cycle, where done may still be
        // left over from the previous job. Done beats timeout in a tie.
        if (srt_done && (tmo_cnt_q != '0)) begin
          rsp_data_d = srt_data_out;
          rsp_err_d  = 1'b0;
          jobs_ok_d  = sat_inc(jobs_ok_q);
          state_d    = StResp;
        end else if (tmo_cnt_q == TmoLast) begin
          rsp_data_d = job_q;
          rsp_err_d  = 1'b1;
          jobs_err_d = sat_inc(jobs_err_q);
          state_d    = StResp;
        end
      end
      StResp: begin
        if (rsp_ready) begin
          ptr_d   = (id_q == IdLast) ? '0 : id_q + IdW'(1);
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      ptr_q      <= '0;
      id_q       <= '0;
      tmo_cnt_q  <= '0;
      job_q      <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
      jobs_ok_q  <= '0;
      jobs_err_q <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      id_q       <= id_d;
      tmo_cnt_q  <= tmo_cnt_d;
      job_q      <= job_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
      jobs_ok_q  <= jobs_ok_d;
      jobs_err_q <= jobs_err_d;
    end
  end

  assign req_ready   = gnt;
  assign rsp_valid   = (state_q == StResp);
  assign rsp_id      = id_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_err     = rsp_err_q;
  assign srt_start   = (state_q == StLaunch);
  assign srt_data_in = job_q;
  assign jobs_ok     = jobs_ok_q;
  assign jobs_err    = jobs_err_q;

endmodule

// File: tb/tb_sort_job_scheduler.sv
// Self-checking bench for sort_job_scheduler with a behavioural sorter and
// a cycle-level reference model of grant order, latency and responses.
module tb_sort_job_scheduler;

  localparam int unsigned NREQ    = 4;
  localparam int unsigned N       = 4;
  localparam int unsigned W       = 8;
  localparam int unsigned TIMEOUT = 64;
  localparam int unsigned DW      = N * W;
  localparam int unsigned IdW     = $clog2(NREQ);

  logic               clk = 1'b0;
  logic               rst_n;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    req_ready;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [IdW-1:0]     rsp_id;
  logic [DW-1:0]      rsp_data;
  logic               rsp_err;
  logic               srt_start;
  logic [DW-1:0]      srt_data_in;
  logic [DW-1:0]      srt_data_out = '0;
  logic               srt_done = 1'b0;
  logic [15:0]        jobs_ok;
  logic [15:0]        jobs_err;

  sort_job_scheduler #(
    .NREQ   (NREQ),
    .N      (N),
    .W      (W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_id      (rsp_id),
    .rsp_data    (rsp_data),
    .rsp_err     (rsp_err),
    .srt_start   (srt_start),
    .srt_data_in (srt_data_in),
    .srt_data_out(srt_data_out),
    .srt_done    (srt_done),
    .jobs_ok     (jobs_ok),
    .jobs_err    (jobs_err)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned ptr_m  = 0;
  int unsigned ok_m   = 0;
  int unsigned err_m  = 0;

  // Sorter model: delay_cfg cycles after the start cycle done rises (0 = never);
  // done stays high until the next start, or one cycle past it with stale_cfg.
  int unsigned   delay_cfg = 0;
  bit            stale_cfg = 1'b0;
  int unsigned   remain = 0;
  bit            stale_pend = 1'b0;
  logic [DW-1:0] sjob = '0;

  // Element i lives at [i*W +: W]; the result puts the smallest at the top.
  function automatic logic [DW-1:0] sort_vec(input logic [DW-1:0] v);
    logic [W-1:0] e[N];
    logic [W-1:0] tmp;
    logic [DW-1:0] r;
    for (int i = 0; i < N; i++) e[i] = v[i*W +: W];
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N - 1 - i; j++)
        if (e[j] > e[j+1]) begin
          tmp = e[j]; e[j] = e[j+1]; e[j+1] = tmp;
        end
    r = '0;
    for (int i = 0; i < N; i++) r[(N-1-i)*W +: W] = e[i];
    return r;
  endfunction

  always @(negedge clk) begin
    if (srt_start) begin
      sjob   = srt_data_in;
      remain = delay_cfg;
      if (stale_cfg) stale_pend = 1'b1;
      else srt_done = 1'b0;
    end else begin
      if (stale_pend) begin
        stale_pend = 1'b0;
        srt_done   = 1'b0;
      end
      if (remain != 0) begin
        remain = remain - 1;
        if (remain == 0) begin
          srt_done     = 1'b1;
          srt_data_out = sort_vec(sjob);
        end
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int unsigned grant_of(input logic [NREQ-1:0] mask, input int unsigned p);
    for (int unsigned off = 0; off < NREQ; off++)
      if (mask[(p + off) % NREQ]) return (p + off) % NREQ;
    return 0;
  endfunction

  function automatic logic [NREQ*DW-1:0] rand_data();
    logic [NREQ*DW-1:0] r;
    for (int i = 0; i < NREQ; i++) r[i*DW +: DW] = DW'($urandom);
    return r;
  endfunction

  task automatic check_zero(input string tag);
    check({tag, "_req_ready"}, req_ready, 0);
    check({tag, "_rsp_valid"}, rsp_valid, 0);
    check({tag, "_rsp_id"}, rsp_id, 0);
    check({tag, "_rsp_data"}, rsp_data, 0);
    check({tag, "_rsp_err"}, rsp_err, 0);
    check({tag, "_srt_start"}, srt_start, 0);
    check({tag, "_srt_data_in"}, srt_data_in, 0);
    check({tag, "_jobs_ok"}, jobs_ok, 0);
    check({tag, "_jobs_err"}, jobs_err, 0);
  endtask

  // One job from IDLE through its response, checked against the model.
  task automatic run_job(input logic [NREQ-1:0] mask, input int unsigned delay,
                         input bit stale, input int unsigned bp,
                         input logic [NREQ*DW-1:0] data,
                         output int unsigned gid, output logic [DW-1:0] obs_data);
    int unsigned   g, t, exp_cyc, d;
    logic [DW-1:0] job, exp_data;
    bit            exp_err, seen, extra, stable;
    g         = grant_of(mask, ptr_m);
    job       = data[g*DW +: DW];
    delay_cfg = delay;
    stale_cfg = stale;
    req_data  = data;
    req_valid = mask;
    rsp_ready = (bp == 0);
    #1;
    check("grant", req_ready, 64'(1) << g);
    t = cyc;
    tick();
    req_valid = '0;
    check("srt_start", srt_start, 1);
    check("srt_data_in", srt_data_in, job);
    check("req_ready_busy", req_ready, 0);

    d = t + 1 + delay;
    if (d < t + 3) d = t + 3;
    if (delay != 0 && d <= t + 1 + TIMEOUT) begin
      exp_cyc  = d + 1;
      exp_data = sort_vec(job);
      exp_err  = 1'b0;
      ok_m++;
    end else begin
      exp_cyc  = t + 2 + TIMEOUT;
      exp_data = job;
      exp_err  = 1'b1;
      err_m++;
    end

    seen  = 1'b0;
    extra = 1'b0;
    for (int k = 0; k < TIMEOUT + 8; k++) begin
      tick();
      if (srt_start) extra = 1'b1;
      if (rsp_valid) begin
        seen = 1'b1;
        break;
      end
    end
    check("rsp_seen", seen, 1);
    check("rsp_latency", cyc - t, exp_cyc - t);
    check("single_start", extra, 0);
    check("rsp_id", rsp_id, g);
    check("rsp_data", rsp_data, exp_data);
    check("rsp_err", rsp_err, exp_err);
    check("jobs_ok", jobs_ok, ok_m);
    check("jobs_err", jobs_err, err_m);
    obs_data = rsp_data;
    gid      = rsp_id;

    if (bp != 0) begin
      req_valid = mask;
      stable    = 1'b1;
      for (int k = 0; k < bp; k++) begin
        tick();
        if (!rsp_valid || rsp_data !== exp_data || rsp_id !== IdW'(g) ||
            rsp_err !== exp_err || req_ready !== '0 || srt_start)
          stable = 1'b0;
      end
      check("backpressure_hold", stable, 1);
      req_valid = '0;
      rsp_ready = 1'b1;
    end
    tick();
    check("idle_after_rsp", rsp_valid, 0);
    ptr_m = (g + 1) % NREQ;
  endtask

  initial begin
    int unsigned        gid, dly;
    logic [DW-1:0]      obs;
    logic [NREQ*DW-1:0] data;
    bit                 seen;

    rst_n     = 1'b0;
    req_valid = '0;
    req_data  = '0;
    rsp_ready = 1'b0;
    repeat (3) tick();
    check_zero("reset");
    rst_n = 1'b1;
    tick();
    check_zero("post_reset");

    // Round-robin with every requester valid.
    for (int k = 0; k < 5; k++) begin
      run_job(4'b1111, $urandom_range(2, 10), 1'b0, 0, rand_data(), gid, obs);
      check("rr_order", gid, k % NREQ);
    end

    // Directed single job from requester 0.
    data = rand_data();
    data[DW-1:0] = 32'h1234_7856;
    run_job(4'b0001, 6, 1'b0, 0, data, gid, obs);
    check("single_sorted", obs, 32'h1234_5678);

    // Timeout and the done/timeout tie boundary.
    run_job(NREQ'($urandom_range(1, 15)), 0, 1'b0, 0, rand_data(), gid, obs);
    run_job(NREQ'($urandom_range(1, 15)), TIMEOUT, 1'b0, 0, rand_data(), gid, obs);
    run_job(NREQ'($urandom_range(1, 15)), TIMEOUT + 1, 1'b0, 0, rand_data(), gid, obs);

    // Stale done carried into the first WAIT cycle.
    run_job(4'b0110, 5, 1'b0, 0, rand_data(), gid, obs);
    run_job(4'b0110, 4, 1'b1, 0, rand_data(), gid, obs);
    run_job(4'b1001, 1, 1'b1, 0, rand_data(), gid, obs);

    // Response backpressure.
    run_job(4'b1010, 7, 1'b0, 10, rand_data(), gid, obs);

    // Randomized jobs.
    for (int k = 0; k < 20; k++) begin
      dly = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 20);
      run_job(NREQ'($urandom_range(1, 15)), dly, 1'($urandom_range(0, 1)),
              $urandom_range(0, 3), rand_data(), gid, obs);
    end

    // Reset in the middle of WAIT; the late done must be ignored.
    req_data  = rand_data();
    req_valid = 4'b0010;
    delay_cfg = 10;
    stale_cfg = 1'b0;
    rsp_ready = 1'b1;
    #1;
    check("mid_reset_grant", req_ready, 4'b0010);
    tick();
    req_valid = '0;
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 15; k++) begin
      tick();
      if (rsp_valid) seen = 1'b1;
    end
    check("no_rsp_after_reset", seen, 0);
    check_zero("mid_reset");
    ptr_m = 0;
    ok_m  = 0;
    err_m = 0;
    req_valid = 4'b1111;
    #1;
    check("ptr_after_reset", req_ready, 4'b0001);
    req_valid = '0;
    run_job(4'b0100, 3, 1'b0, 0, rand_data(), gid, obs);
    check("grant_req2_after_reset", gid, 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
